bus_hold_arbiter: RTL



---
 rtl/bus_arb_pkg.sv | 30 +++
 rtl/bus_hold_arbiter_rr_pick.sv | 36 +++
 rtl/bus_hold_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types, counter widths and one-hot/index helpers for the bus hold arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    OWN,
    TURN,
    RELEASE
  } arbState_t;

  localparam int TURN_CNT_W  = 4;
  localparam int BURST_CNT_W = 8;
  localparam int MAX_REQ     = 8;
  localparam int MAX_IDX_W   = 3;

  function automatic logic [MAX_REQ-1:0] idxToOnehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehotToIdx(input logic [MAX_REQ-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_hold_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rrPtr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rrPtr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] rotIdx [NUM_REQ];

  // rotIdx[k] is the master examined at priority k (0 = highest).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum        = {1'b0, rrPtr} + (IDX_W+1)'(gi);
      assign rotIdx[gi] = IDX_W'((sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum);
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[rotIdx[i]]) begin
        valid = 1'b1;
        index = rotIdx[i];
      end
    end
  end

endmodule

// File: rtl/bus_hold_arbiter.sv
// HOLD/HOLDA bus arbiter for non-CPU 8088 bus masters with round-robin handoff.
// Optional grant-length limit enabled by defining BUS_ARB_BURST_LIMIT_EN.
module bus_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 64
) (
  input  logic                       CLKx4,
  input  logic                       RESET,
  input  logic [NUM_REQ-1:0]         REQ,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic [$clog2(NUM_REQ)-1:0] OWNER,
  output logic                       BUS_EN,
  output logic                       HOLD,
  input  logic                       HOLDA,
  output logic                       BUSY,
  output logic                       ERR
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arbState_t               stateReg, stateNext;
  logic                    holdReg, holdNext;
  logic [NUM_REQ-1:0]      grantReg, grantNext;
  logic [IDX_W-1:0]        ownerReg, ownerNext;
  logic [IDX_W-1:0]        rrPtrReg, rrPtrNext;
  logic                    busEnReg, busEnNext;
  logic                    busyReg, busyNext;
  logic                    errReg, errNext;
  logic [TURN_CNT_W-1:0]   turnCntReg, turnCntNext;

  logic                    pickValid;
  logic [IDX_W-1:0]        pickIdx;
  logic                    revoke;

  rr_pick #(.NUM_REQ(NUM_REQ)) picker (
    .req   (REQ),
    .rrPtr (rrPtrReg),
    .valid (pickValid),
    .index (pickIdx)
  );

`ifdef BUS_ARB_BURST_LIMIT_EN
  logic [BURST_CNT_W-1:0] burstCntReg, burstCntNext;

  // Counts completed OWN cycles of the current grant; saturates.
  always_comb begin
    burstCntNext = '0;
    if (stateReg == OWN && stateNext == OWN && burstCntReg != '1)
      burstCntNext = burstCntReg + 1'b1;
    else if (stateReg == OWN && stateNext == OWN)
      burstCntNext = burstCntReg;
  end

  always_ff @(posedge CLKx4) begin
    if (RESET) burstCntReg <= '0;
    else       burstCntReg <= burstCntNext;
  end

  assign revoke = (|(REQ & ~grantReg)) && (burstCntReg >= BURST_CNT_W'(MAX_BURST - 1));
`else
  assign revoke = 1'b0;
`endif

  always_comb begin
    stateNext   = stateReg;
    holdNext    = holdReg;
    grantNext   = grantReg;
    ownerNext   = ownerReg;
    rrPtrNext   = rrPtrReg;
    busEnNext   = busEnReg;
    errNext     = errReg;
    turnCntNext = turnCntReg;

    case (stateReg)
      IDLE: begin
        if (|REQ) begin
          holdNext  = 1'b1;
          stateNext = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (HOLDA) begin
          if (pickValid) begin
            grantNext = NUM_REQ'(idxToOnehot(MAX_IDX_W'(pickIdx)));
            ownerNext = pickIdx;
            busEnNext = 1'b1;
            stateNext = OWN;
          end else begin
            holdNext  = 1'b0;
            stateNext = RELEASE;
          end
        end
      end
      OWN, TURN: begin
        if (!HOLDA) begin
          // CPU took the bus back under a live grant.
          grantNext = '0;
          busEnNext = 1'b0;
          holdNext  = 1'b0;
          errNext   = 1'b1;
          stateNext = RELEASE;
        end else if (stateReg == OWN) begin
          if (!REQ[ownerReg] || revoke) begin
            grantNext   = '0;
            busEnNext   = 1'b0;
            rrPtrNext   = (ownerReg == IDX_W'(NUM_REQ - 1)) ? '0 : ownerReg + 1'b1;
            turnCntNext = TURN_CNT_W'(TURN_CYCLES);
            stateNext   = TURN;
          end
        end else if (turnCntReg <= TURN_CNT_W'(1)) begin
          turnCntNext = '0;
          if (pickValid) begin
            grantNext = NUM_REQ'(idxToOnehot(MAX_IDX_W'(pickIdx)));
            ownerNext = pickIdx;
            busEnNext = 1'b1;
            stateNext = OWN;
          end else begin
            holdNext  = 1'b0;
            stateNext = RELEASE;
          end
        end else begin
          turnCntNext = turnCntReg - 1'b1;
        end
      end
      RELEASE: begin
        if (!HOLDA) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      stateReg   <= IDLE;
      holdReg    <= 1'b0;
      grantReg   <= '0;
      ownerReg   <= '0;
      rrPtrReg   <= '0;
      busEnReg   <= 1'b0;
      busyReg    <= 1'b0;
      errReg     <= 1'b0;
      turnCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      holdReg    <= holdNext;
      grantReg   <= grantNext;
      ownerReg   <= ownerNext;
      rrPtrReg   <= rrPtrNext;
      busEnReg   <= busEnNext;
      busyReg    <= busyNext;
      errReg     <= errNext;
      turnCntReg <= turnCntNext;
    end
  end

  assign GRANT  = grantReg;
  assign OWNER  = ownerReg;
  assign BUS_EN = busEnReg;
  assign HOLD   = holdReg;
  assign BUSY   = busyReg;
  assign ERR    = errReg;

endmodule
